// File: rtl/disp_ccm.sv
// 3x3 colour-correction matrix on linear RGB, frame-synchronous coefficient shadowing.
// Latency 3 cycles when enabled, 0 (combinational bypass) when disabled; no backpressure.
module disp_ccm #(
  parameter int IN_DW   = 12,
  parameter int OUT_DW  = 12,
  parameter int COEF_DW = 12,
  parameter int FRAC_BW = 10,
  parameter int OFS_DW  = 13,
  parameter int MAXIMUM = 4095
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   vsync_in,
  input  logic                   de_in,
  input  logic [IN_DW-1:0]       r_in,
  input  logic [IN_DW-1:0]       g_in,
  input  logic [IN_DW-1:0]       b_in,
  input  logic                   reg_ccm_en,
  input  logic [9*COEF_DW-1:0]   reg_coef,
  input  logic [OFS_DW-1:0]      reg_ofs_r,
  input  logic [OFS_DW-1:0]      reg_ofs_g,
  input  logic [OFS_DW-1:0]      reg_ofs_b,
  output logic                   vsync_out,
  output logic                   de_out,
  output logic [OUT_DW-1:0]      r_out,
  output logic [OUT_DW-1:0]      g_out,
  output logic [OUT_DW-1:0]      b_out,
  output logic                   coef_upd
);

  localparam int PROD_W = IN_DW + 1 + COEF_DW;
  localparam int ACC_W  = PROD_W + 3;
  localparam int SH_W   = ACC_W - FRAC_BW;
  localparam logic signed [ACC_W-1:0]     RND   = ACC_W'(2 ** (FRAC_BW - 1));
  localparam logic signed [SH_W-1:0]      MAX_S = SH_W'(MAXIMUM);
  localparam logic signed [COEF_DW-1:0]   ONE   = COEF_DW'(2 ** FRAC_BW);

  logic                        vs_d;
  logic                        vs_rise;
  logic                        en_act;
  logic signed [COEF_DW-1:0]   coef_act [9];
  logic signed [OFS_DW-1:0]    ofs_act  [3];
  logic signed [IN_DW:0]       pix_in   [3];
  logic signed [PROD_W-1:0]    prod     [9];
  logic signed [ACC_W-1:0]     acc      [3];
  logic signed [SH_W-1:0]      sh       [3];
  logic [OUT_DW-1:0]           clip     [3];
  logic [OUT_DW-1:0]           pix_q    [3];
  logic [2:0]                  vs_pipe;
  logic [2:0]                  de_pipe;

  assign vs_rise   = vsync_in & ~vs_d;
  assign pix_in[0] = $signed({1'b0, r_in});
  assign pix_in[1] = $signed({1'b0, g_in});
  assign pix_in[2] = $signed({1'b0, b_in});

  // Active set only moves on the vsync rising edge so a frame never mixes coefficient sets.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vs_d     <= 1'b0;
      en_act   <= 1'b0;
      coef_upd <= 1'b0;
      for (int i = 0; i < 9; i++) coef_act[i] <= (i % 4 == 0) ? ONE : '0;
      for (int c = 0; c < 3; c++) ofs_act[c] <= '0;
    end else begin
      vs_d     <= vsync_in;
      coef_upd <= vs_rise;
      if (vs_rise) begin
        en_act     <= reg_ccm_en;
        for (int i = 0; i < 9; i++) coef_act[i] <= $signed(reg_coef[i*COEF_DW +: COEF_DW]);
        ofs_act[0] <= $signed(reg_ofs_r);
        ofs_act[1] <= $signed(reg_ofs_g);
        ofs_act[2] <= $signed(reg_ofs_b);
      end
    end
  end

  always_comb begin
    for (int c = 0; c < 3; c++) begin
      sh[c]   = $signed(acc[c][ACC_W-1:FRAC_BW]);
      clip[c] = sh[c][OUT_DW-1:0];
      if (sh[c][SH_W-1])      clip[c] = '0;
      else if (sh[c] > MAX_S) clip[c] = OUT_DW'(MAXIMUM);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vs_pipe <= '0;
      de_pipe <= '0;
      for (int i = 0; i < 9; i++) prod[i] <= '0;
      for (int c = 0; c < 3; c++) begin
        acc[c]   <= '0;
        pix_q[c] <= '0;
      end
    end else begin
      vs_pipe <= {vs_pipe[1:0], vsync_in};
      de_pipe <= {de_pipe[1:0], de_in};
      for (int i = 0; i < 9; i++)
        prod[i] <= PROD_W'(pix_in[i % 3]) * PROD_W'(coef_act[i]);
      // Row c of the matrix produces channel c; rounding constant makes the shift round-half-up.
      for (int c = 0; c < 3; c++) begin
        acc[c]   <= ACC_W'(prod[3*c]) + ACC_W'(prod[3*c+1]) + ACC_W'(prod[3*c+2])
                  + (ACC_W'(ofs_act[c]) <<< FRAC_BW) + RND;
        pix_q[c] <= de_pipe[1] ? clip[c] : '0;
      end
    end
  end

  assign vsync_out = en_act ? vs_pipe[2] : vsync_in;
  assign de_out    = en_act ? de_pipe[2] : de_in;
  assign r_out     = en_act ? pix_q[0]   : OUT_DW'(r_in);
  assign g_out     = en_act ? pix_q[1]   : OUT_DW'(g_in);
  assign b_out     = en_act ? pix_q[2]   : OUT_DW'(b_in);

endmodule

// File: tb/tb_disp_ccm.sv
// Directed bench for disp_ccm: identity, clipping, rounding, offsets, frame-sync loading, bypass, reset.
module tb_disp_ccm;

  logic          clk = 1'b0;
  logic          rstn;
  logic          vsync_in, de_in, reg_ccm_en;
  logic [11:0]   r_in, g_in, b_in;
  logic [107:0]  reg_coef;
  logic [12:0]   reg_ofs_r, reg_ofs_g, reg_ofs_b;
  logic          vsync_out, de_out, coef_upd;
  logic [11:0]   r_out, g_out, b_out;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  disp_ccm dut (
    .clk(clk), .rstn(rstn), .vsync_in(vsync_in), .de_in(de_in),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .reg_ccm_en(reg_ccm_en), .reg_coef(reg_coef),
    .reg_ofs_r(reg_ofs_r), .reg_ofs_g(reg_ofs_g), .reg_ofs_b(reg_ofs_b),
    .vsync_out(vsync_out), .de_out(de_out),
    .r_out(r_out), .g_out(g_out), .b_out(b_out), .coef_upd(coef_upd)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [107:0] cm(input int c00, c01, c02, c10, c11, c12, c20, c21, c22);
    return {12'(c22), 12'(c21), 12'(c20), 12'(c12), 12'(c11), 12'(c10), 12'(c02), 12'(c01), 12'(c00)};
  endfunction

  task automatic load(input logic [107:0] c, input int ofr, ofg, ofb, input logic en);
    reg_coef   = c;
    reg_ofs_r  = 13'(ofr);
    reg_ofs_g  = 13'(ofg);
    reg_ofs_b  = 13'(ofb);
    reg_ccm_en = en;
    vsync_in   = 1'b1;
    tick();
    vsync_in   = 1'b0;
    tick();
  endtask

  // One-cycle pixel; on return the DUT outputs carry that pixel (3-cycle latency).
  task automatic pix(input int r, g, b);
    r_in  = 12'(r);
    g_in  = 12'(g);
    b_in  = 12'(b);
    de_in = 1'b1;
    tick();
    de_in = 1'b0;
    tick();
    tick();
  endtask

  logic [107:0] ident;

  initial begin
    ident      = cm(1024, 0, 0, 0, 1024, 0, 0, 0, 1024);
    rstn       = 1'b0;
    vsync_in   = 1'b0;
    de_in      = 1'b1;
    r_in       = 12'h111;
    g_in       = 12'h222;
    b_in       = 12'h333;
    reg_ccm_en = 1'b0;
    reg_coef   = ident;
    reg_ofs_r  = '0;
    reg_ofs_g  = '0;
    reg_ofs_b  = '0;
    tick();
    tick();
    chk("rst_bypass_r", r_out, 12'h111);
    chk("rst_bypass_b", b_out, 12'h333);
    chk("rst_bypass_de", de_out, 1);
    chk("rst_coef_upd", coef_upd, 0);
    rstn  = 1'b1;
    de_in = 1'b0;
    tick();

    // Identity enable, coef_upd pulse and vsync latency
    reg_ccm_en = 1'b1;
    vsync_in   = 1'b1;
    tick();
    chk("upd_pulse", cof_or(coef_upd), 1);
    chk("vs_out_e1", vsync_out, 0);
    vsync_in = 1'b0;
    tick();
    chk("upd_once", coef_upd, 0);
    chk("vs_out_e2", vsync_out, 0);
    tick();
    chk("vs_out_e3", vsync_out, 1);
    tick();
    chk("vs_out_e4", vsync_out, 0);

    r_in = 12'h555;
    tick(); tick(); tick();
    chk("blank_r", r_out, 0);
    chk("blank_de", de_out, 0);

    r_in = 12'd1000; g_in = 12'd2000; b_in = 12'd3000; de_in = 1'b1;
    tick();
    chk("id_de_l1", de_out, 0);
    de_in = 1'b0;
    tick();
    chk("id_de_l2", de_out, 0);
    tick();
    chk("id_de_l3", de_out, 1);
    chk("id_r", r_out, 1000);
    chk("id_g", g_out, 2000);
    chk("id_b", b_out, 3000);
    tick();
    chk("id_de_l4", de_out, 0);

    load(cm(2047, 0, 0, 0, 1024, 0, 0, 0, 1024), 0, 0, 0, 1'b1);
    pix(4000, 0, 0);
    chk("sat_r", r_out, 4095);
    chk("sat_g", g_out, 0);

    load(cm(512, 0, 0, 0, 1024, 0, 0, 0, 1024), 0, 0, 0, 1'b1);
    pix(3, 0, 0);
    chk("round_3", r_out, 2);
    pix(1, 7, 0);
    chk("round_1", r_out, 1);
    chk("round_g", g_out, 7);

    load(cm(0, -1024, 0, 0, 1024, 0, 0, 0, 1024), 0, 0, 0, 1'b1);
    pix(0, 500, 0);
    chk("neg_clip_r", r_out, 0);
    chk("neg_g", g_out, 500);

    load(ident, 100, 0, -100, 1'b1);
    pix(50, 100, 300);
    chk("ofs_r", r_out, 150);
    chk("ofs_g", g_out, 100);
    chk("ofs_b", b_out, 200);

    // Mid-frame register write must wait for the next vsync edge
    load(ident, 0, 0, 0, 1'b1);
    reg_coef = cm(512, 0, 0, 0, 1024, 0, 0, 0, 1024);
    pix(800, 0, 0);
    chk("fsync_hold", r_out, 800);
    load(reg_coef, 0, 0, 0, 1'b1);
    pix(800, 0, 0);
    chk("fsync_new", r_out, 400);

    // vsync held high: only the edge loads
    reg_coef = cm(256, 0, 0, 0, 1024, 0, 0, 0, 1024);
    vsync_in = 1'b1;
    tick();
    chk("hold_upd1", coef_upd, 1);
    reg_coef = cm(768, 0, 0, 0, 1024, 0, 0, 0, 1024);
    tick();
    chk("hold_upd2", coef_upd, 0);
    tick();
    chk("hold_upd3", coef_upd, 0);
    vsync_in = 1'b0;
    tick();
    pix(800, 0, 0);
    chk("hold_edge", r_out, 200);

    // Bypass
    load(ident, 0, 0, 0, 1'b0);
    r_in = 12'h123; g_in = 12'h456; de_in = 1'b0;
    #1;
    chk("byp_r", r_out, 12'h123);
    chk("byp_g", g_out, 12'h456);
    chk("byp_de", de_out, 0);

    // Reset mid-frame
    load(ident, 0, 0, 0, 1'b1);
    r_in = 12'd700; de_in = 1'b1;
    tick(); tick();
    rstn = 1'b0;
    #1;
    chk("mrst_r", r_out, 700);
    chk("mrst_de", de_out, 1);
    chk("mrst_upd", coef_upd, 0);
    tick();
    rstn = 1'b1;
    de_in = 1'b0;
    tick(); tick(); tick();
    r_in = 12'h2AB;
    #1;
    chk("post_rst_byp", r_out, 12'h2AB);
    load(cm(512, 0, 0, 0, 1024, 0, 0, 0, 1024), 0, 0, 0, 1'b1);
    pix(600, 0, 0);
    chk("post_rst_en", r_out, 300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  function automatic logic coof_dummy(input logic x);
    return x;
  endfunction

  function automatic logic cof_or(input logic x);
    return coof_dummy(x);
  endfunction

endmodule
